dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the bus cycles waited for ack before abort (range 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port dmem_valid_i  input  1  core-side request valid, held stable by the requester until dmem_ready_o.
REQ-005 SHALL have port dmem_ready_o  output  1  one-cycle response strobe (read data/error valid, write complete).
REQ-006 SHALL have port dmem_addr_i  input  32  byte address.
REQ-007 SHALL have port dmem_wdata_i  input  32  lane-aligned write data.
REQ-008 SHALL have port dmem_we_i  input  4  byte write enables; 4'h0 means read.
REQ-009 SHALL have port dmem_rdata_o  output  32  registered read data.
REQ-010 SHALL have port dmem_err_o  output  1  bus error/timeout flag, valid only with dmem_ready_o.
REQ-011 SHALL have port bus_req_o  output  1  system-bus request, registered.
REQ-012 SHALL have ports bus_addr_o (output 32, word-aligned with addr[1:0]=0), bus_wdata_o (output 32), bus_be_o (output 4), bus_we_o (output 1): registered copies of the latched request.
REQ-013 SHALL have port bus_ack_i  input  1  bus completion.
REQ-014 SHALL have port bus_err_i  input  1  bus error completion.
REQ-015 SHALL have port bus_rdata_i  input  32  read data, valid with bus_ack_i.

Function
REQ-016 SHALL implement states IDLE, REQ, RESP.
REQ-017 IDLE with dmem_valid_i=1 SHALL latch addr/wdata/we, set bus_req_o=1 next cycle, go to REQ; bus_be_o = dmem_we_i for writes, 4'hF for reads; bus_we_o = |dmem_we_i.
REQ-018 REQ SHALL hold bus_req_o and all bus_* outputs constant until bus_ack_i or bus_err_i.
REQ-019 REQ with bus_ack_i=1, bus_err_i=0 SHALL capture bus_rdata_i into dmem_rdata_o for reads only, clear bus_req_o, go to RESP.
REQ-020 REQ with bus_err_i=1 (regardless of bus_ack_i) SHALL clear bus_req_o, set error flag, set dmem_rdata_o=0, go to RESP.
REQ-021 RESP SHALL assert dmem_ready_o for exactly one cycle, with dmem_err_o per REQ-019/020, then return to IDLE.
REQ-022 Latency: valid sampled at cycle 0 -> bus_req_o at cycle 1 -> ack at cycle k>=1 -> dmem_ready_o at cycle k+1; minimum 2 cycles.
REQ-023 bus_ack_i/bus_err_i outside REQ SHALL be ignored.
REQ-024 dmem_valid_i in REQ or RESP SHALL be ignored; a new request is sampled only in IDLE (the earliest is the cycle after the ready strobe).
REQ-025 dmem_rdata_o SHALL hold its last value except at the REQ-019/020 update points; unchanged by writes.
REQ-026 dmem_ready_o and dmem_err_o SHALL be 0 in IDLE and REQ.

Reset
REQ-027 rst=1 SHALL force IDLE on the next edge, aborting any in-flight transfer without a ready strobe.
REQ-028 Reset values: bus_req_o=0, bus_addr_o=0, bus_wdata_o=0, bus_be_o=0, bus_we_o=0, dmem_ready_o=0, dmem_err_o=0, dmem_rdata_o=0, timeout counter=0.

Configuration
REQ-029 With DMEM_BRIDGE_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entering REQ and increment each REQ cycle without a response; on reaching TIMEOUT_CYCLES it SHALL drop bus_req_o and go to RESP with dmem_err_o=1 and dmem_rdata_o=0.
REQ-030 Without DMEM_BRIDGE_TIMEOUT_EN, the counter SHALL be absent and REQ SHALL wait indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-031 Read addr 0x1004, ack at bus cycle 1 with rdata 0xDEADBEEF -> bus_be_o=4'hF, bus_we_o=0, ready at cycle 2, rdata_o=0xDEADBEEF, err=0.
REQ-032 Byte write addr 0x2003, we=4'b1000, wdata=0xAB000000, ack after 3 wait cycles -> bus_addr_o=0x2000, bus_be_o=4'b1000, ready one cycle after ack, rdata_o unchanged.
REQ-033 Read with bus_ack_i=1 and bus_err_i=1 together -> ready with err=1, rdata_o=0.
REQ-034 With DMEM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> bus_req_o drops after 4 REQ cycles, ready+err next cycle; late ack ignored.
REQ-035 rst=1 during REQ -> next cycle bus_req_o=0, IDLE, no ready strobe; a new request afterwards completes normally.
REQ-036 Back-to-back reads with valid held high -> second bus_req_o rises only the cycle after the first ready strobe.

Source files
------------

// File: rtl/dmem_bridge.sv
// Core data-memory port to single-outstanding system-bus bridge (IDLE -> REQ -> RESP).
// Optional ack timeout: define DMEM_BRIDGE_TIMEOUT_EN to enable it.
module dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_valid_i,
    output logic        dmem_ready_o,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    input  logic [3:0]  dmem_we_i,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_err_o,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    output logic        bus_we_o,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state_q;
    logic        ready_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        req_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        we_q;

    // Byte offset is dropped: the bus is word-addressed and lanes come from bus_be_o.
    logic unused_addr_bits;
    assign unused_addr_bits = ^dmem_addr_i[1:0];

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_out_of_range
    end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dmem_valid_i) begin
                        addr_q  <= {dmem_addr_i[31:2], 2'b00};
                        wdata_q <= dmem_wdata_i;
                        be_q    <= (|dmem_we_i) ? dmem_we_i : 4'hF;
                        we_q    <= |dmem_we_i;
                        req_q   <= 1'b1;
                        state_q <= REQ;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                REQ: begin
                    if (bus_err_i) begin
                        req_q   <= 1'b0;
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state_q <= RESP;
                    end else if (bus_ack_i) begin
                        req_q   <= 1'b0;
                        ready_q <= 1'b1;
                        if (!we_q) rdata_q <= bus_rdata_i;
                        state_q <= RESP;
                    end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + 16'd1;
                        // Terminate on the cycle the counter reaches the limit.
                        if (cnt_q + 16'd1 == TMO) begin
                            req_q   <= 1'b0;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state_q <= RESP;
                        end
                    end
`endif
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_ready_o = ready_q;
    assign dmem_err_o   = err_q;
    assign dmem_rdata_o = rdata_q;
    assign bus_req_o    = req_q;
    assign bus_addr_o   = addr_q;
    assign bus_wdata_o  = wdata_q;
    assign bus_be_o     = be_q;
    assign bus_we_o     = we_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: reads, writes, error/ack collisions, reset abort,
// back-to-back requests and (with DMEM_BRIDGE_TIMEOUT_EN) the ack timeout.
module tb_dmem_bridge;

    logic        clk;
    logic        rst;
    logic        dmem_valid_i;
    logic        dmem_ready_o;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_wdata_i;
    logic [3:0]  dmem_we_i;
    logic [31:0] dmem_rdata_o;
    logic        dmem_err_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_we_o;
    logic        bus_ack_i;
    logic        bus_err_i;
    logic [31:0] bus_rdata_i;

    int checks = 0;
    int errors = 0;

    dmem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .dmem_valid_i (dmem_valid_i),
        .dmem_ready_o (dmem_ready_o),
        .dmem_addr_i  (dmem_addr_i),
        .dmem_wdata_i (dmem_wdata_i),
        .dmem_we_i    (dmem_we_i),
        .dmem_rdata_o (dmem_rdata_o),
        .dmem_err_o   (dmem_err_o),
        .bus_req_o    (bus_req_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_be_o     (bus_be_o),
        .bus_we_o     (bus_we_o),
        .bus_ack_i    (bus_ack_i),
        .bus_err_i    (bus_err_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        dmem_valid_i = 1'b0;
        dmem_addr_i = '0;
        dmem_wdata_i = '0;
        dmem_we_i = '0;
        bus_ack_i = 1'b0;
        bus_err_i = 1'b0;
        bus_rdata_i = '0;
        step();
        step();

        // Reset state
        chk("rst_req",   {31'd0, bus_req_o},    32'd0);
        chk("rst_addr",  bus_addr_o,            32'd0);
        chk("rst_wdata", bus_wdata_o,           32'd0);
        chk("rst_be",    {28'd0, bus_be_o},     32'd0);
        chk("rst_we",    {31'd0, bus_we_o},     32'd0);
        chk("rst_ready", {31'd0, dmem_ready_o}, 32'd0);
        chk("rst_err",   {31'd0, dmem_err_o},   32'd0);
        chk("rst_rdata", dmem_rdata_o,          32'd0);
        rst = 1'b0;
        step();

        // Read 0x1004, ack in bus cycle 1
        dmem_valid_i = 1'b1;
        dmem_addr_i = 32'h0000_1004;
        dmem_we_i = 4'h0;
        step();
        chk("rd_req",   {31'd0, bus_req_o},    32'd1);
        chk("rd_addr",  bus_addr_o,            32'h0000_1004);
        chk("rd_be",    {28'd0, bus_be_o},     32'hF);
        chk("rd_we",    {31'd0, bus_we_o},     32'd0);
        chk("rd_rdy0",  {31'd0, dmem_ready_o}, 32'd0);
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'hDEAD_BEEF;
        step();
        chk("rd_rdy",   {31'd0, dmem_ready_o}, 32'd1);
        chk("rd_data",  dmem_rdata_o,          32'hDEAD_BEEF);
        chk("rd_err",   {31'd0, dmem_err_o},   32'd0);
        chk("rd_reqlo", {31'd0, bus_req_o},    32'd0);
        dmem_valid_i = 1'b0;
        bus_rdata_i = 32'h5555_5555;
        step();
        chk("rd_rdy_1cyc", {31'd0, dmem_ready_o}, 32'd0);

        // Stray ack while idle is ignored
        step();
        chk("idle_ack_rdy",  {31'd0, dmem_ready_o}, 32'd0);
        chk("idle_ack_req",  {31'd0, bus_req_o},    32'd0);
        chk("idle_ack_data", dmem_rdata_o,          32'hDEAD_BEEF);
        bus_ack_i = 1'b0;

        // Byte write 0x2003, ack after 3 wait cycles
        dmem_valid_i = 1'b1;
        dmem_addr_i = 32'h0000_2003;
        dmem_we_i = 4'b1000;
        dmem_wdata_i = 32'hAB00_0000;
        step();
        chk("wr_req",   {31'd0, bus_req_o},    32'd1);
        chk("wr_addr",  bus_addr_o,            32'h0000_2000);
        chk("wr_be",    {28'd0, bus_be_o},     32'h8);
        chk("wr_we",    {31'd0, bus_we_o},     32'd1);
        chk("wr_wdata", bus_wdata_o,           32'hAB00_0000);
        dmem_addr_i = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wr_wait_req",  {31'd0, bus_req_o},    32'd1);
            chk("wr_wait_rdy",  {31'd0, dmem_ready_o}, 32'd0);
            chk("wr_wait_addr", bus_addr_o,            32'h0000_2000);
        end
        bus_ack_i = 1'b1;
        step();
        chk("wr_rdy",   {31'd0, dmem_ready_o}, 32'd1);
        chk("wr_err",   {31'd0, dmem_err_o},   32'd0);
        chk("wr_rdata", dmem_rdata_o,          32'hDEAD_BEEF);
        chk("wr_reqlo", {31'd0, bus_req_o},    32'd0);
        dmem_valid_i = 1'b0;
        bus_ack_i = 1'b0;
        step();

        // Read with ack and err together -> error, rdata cleared
        dmem_valid_i = 1'b1;
        dmem_addr_i = 32'h0000_3008;
        dmem_we_i = 4'h0;
        step();
        chk("ae_req", {31'd0, bus_req_o}, 32'd1);
        bus_ack_i = 1'b1;
        bus_err_i = 1'b1;
        bus_rdata_i = 32'h1234_5678;
        step();
        chk("ae_rdy",   {31'd0, dmem_ready_o}, 32'd1);
        chk("ae_err",   {31'd0, dmem_err_o},   32'd1);
        chk("ae_rdata", dmem_rdata_o,          32'd0);
        dmem_valid_i = 1'b0;
        bus_ack_i = 1'b0;
        bus_err_i = 1'b0;
        step();
        chk("ae_err_clr", {31'd0, dmem_err_o},   32'd0);
        chk("ae_rdy_clr", {31'd0, dmem_ready_o}, 32'd0);

        // Reset during REQ aborts without a ready strobe
        dmem_valid_i = 1'b1;
        dmem_addr_i = 32'h0000_4000;
        step();
        chk("ra_req", {31'd0, bus_req_o}, 32'd1);
        rst = 1'b1;
        dmem_valid_i = 1'b0;
        step();
        chk("ra_reqlo", {31'd0, bus_req_o},    32'd0);
        chk("ra_rdy",   {31'd0, dmem_ready_o}, 32'd0);
        rst = 1'b0;
        bus_ack_i = 1'b1;
        step();
        chk("ra_rdy2",  {31'd0, dmem_ready_o}, 32'd0);
        chk("ra_idle",  {31'd0, bus_req_o},    32'd0);
        bus_ack_i = 1'b0;
        dmem_valid_i = 1'b1;
        dmem_addr_i = 32'h0000_5004;
        bus_rdata_i = 32'hCAFE_F00D;
        step();
        chk("ra_new_req",  {31'd0, bus_req_o}, 32'd1);
        chk("ra_new_addr", bus_addr_o,         32'h0000_5004);
        bus_ack_i = 1'b1;
        step();
        chk("ra_new_rdy",  {31'd0, dmem_ready_o}, 32'd1);
        chk("ra_new_data", dmem_rdata_o,          32'hCAFE_F00D);

        // Back-to-back reads with valid and ack held high
        dmem_addr_i = 32'h0000_6000;
        bus_rdata_i = 32'h1111_1111;
        step();
        chk("bb_idle_req", {31'd0, bus_req_o},    32'd0);
        chk("bb_idle_rdy", {31'd0, dmem_ready_o}, 32'd0);
        step();
        chk("bb1_req", {31'd0, bus_req_o}, 32'd1);
        step();
        chk("bb1_rdy",   {31'd0, dmem_ready_o}, 32'd1);
        chk("bb1_reqlo", {31'd0, bus_req_o},    32'd0);
        chk("bb1_data",  dmem_rdata_o,          32'h1111_1111);
        bus_rdata_i = 32'h2222_2222;
        step();
        chk("bb_gap_req", {31'd0, bus_req_o},    32'd0);
        chk("bb_gap_rdy", {31'd0, dmem_ready_o}, 32'd0);
        step();
        chk("bb2_req", {31'd0, bus_req_o}, 32'd1);
        step();
        chk("bb2_rdy",  {31'd0, dmem_ready_o}, 32'd1);
        chk("bb2_data", dmem_rdata_o,          32'h2222_2222);
        dmem_valid_i = 1'b0;
        bus_ack_i = 1'b0;
        step();

`ifdef DMEM_BRIDGE_TIMEOUT_EN
        // No ack: timeout after 4 REQ cycles, late ack ignored
        dmem_valid_i = 1'b1;
        dmem_addr_i = 32'h0000_7000;
        step();
        chk("to_req1", {31'd0, bus_req_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_wait_req", {31'd0, bus_req_o},    32'd1);
            chk("to_wait_rdy", {31'd0, dmem_ready_o}, 32'd0);
        end
        step();
        chk("to_reqlo", {31'd0, bus_req_o},    32'd0);
        chk("to_rdy",   {31'd0, dmem_ready_o}, 32'd1);
        chk("to_err",   {31'd0, dmem_err_o},   32'd1);
        chk("to_rdata", dmem_rdata_o,          32'd0);
        dmem_valid_i = 1'b0;
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'h3333_3333;
        step();
        chk("to_late_rdy", {31'd0, dmem_ready_o}, 32'd0);
        step();
        chk("to_late_rdy2",  {31'd0, dmem_ready_o}, 32'd0);
        chk("to_late_rdata", dmem_rdata_o,          32'd0);
        bus_ack_i = 1'b0;
`else
        // Without the timeout, REQ waits indefinitely for the bus
        dmem_valid_i = 1'b1;
        dmem_addr_i = 32'h0000_7000;
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("nt_wait_req", {31'd0, bus_req_o},    32'd1);
            chk("nt_wait_rdy", {31'd0, dmem_ready_o}, 32'd0);
        end
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'h4444_4444;
        step();
        chk("nt_rdy",  {31'd0, dmem_ready_o}, 32'd1);
        chk("nt_err",  {31'd0, dmem_err_o},   32'd0);
        chk("nt_data", dmem_rdata_o,          32'h4444_4444);
        dmem_valid_i = 1'b0;
        bus_ack_i = 1'b0;
`endif
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
